// File: rtl/pmem_line_adapter_pkg.sv
// Shared types for the cache-to-physical-memory path: RV32I word type and
// line/beat geometry plus the line adapter state encoding.
package rv32i_types;
    typedef logic [31:0] rv32i_word;
endpackage

package cache_pkg;
    localparam int LINE_BITS   = 256;
    localparam int BEAT_BITS   = 64;
    localparam int BEATS       = 4;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        HOLD
    } pmem_adapter_state_t;
endpackage

// File: rtl/pmem_line_adapter_if.sv
// Cache-side line port and memory-side burst port of the line adapter.
interface pmem_line_if;
    import rv32i_types::*;
    import cache_pkg::*;

    rv32i_word              line_address;
    logic                   line_read;
    logic                   line_write;
    logic [LINE_BITS-1:0]   line_wdata;
    logic [LINE_BITS-1:0]   line_rdata;
    logic                   line_resp;

    modport master (
        output line_address, line_read, line_write, line_wdata,
        input  line_rdata, line_resp
    );
    modport slave (
        input  line_address, line_read, line_write, line_wdata,
        output line_rdata, line_resp
    );
endinterface

interface pmem_burst_if;
    import rv32i_types::*;
    import cache_pkg::*;

    rv32i_word              mem_address;
    logic                   mem_read;
    logic                   mem_write;
    logic [BEAT_BITS-1:0]   mem_wdata;
    logic [BEAT_BITS-1:0]   mem_rdata;
    logic                   mem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_wdata,
        input  mem_rdata, mem_resp
    );
    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/pmem_line_adapter.sv
// Turns 256-bit cache line reads/writes into four-beat 64-bit memory bursts
// and returns a one-cycle line_resp the cache uses as its array write enable.
module pmem_line_adapter
    import cache_pkg::*;
    import rv32i_types::*;
#(
    parameter int HOLDOFF = 2
) (
    input  logic            clk,
    input  logic            rst,
    pmem_line_if.slave      line,
    pmem_burst_if.master    mem
);

    localparam rv32i_word LINE_MASK = ~rv32i_word'((1 << OFFSET_BITS) - 1);
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    pmem_adapter_state_t    state;
    logic [1:0]             beat;
    logic [7:0]             hold_cnt;
    rv32i_word              addr_q;
    logic [LINE_BITS-1:0]   wdata_q;
    logic [LINE_BITS-1:0]   rdata_q;
    logic                   rd_q;
    logic                   wr_q;
    logic                   resp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat     <= '0;
            hold_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            resp_q   <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Write first: a dirty writeback must land before its fill.
                    if (line.line_write) begin
                        wdata_q <= line.line_wdata;
                        addr_q  <= line.line_address & LINE_MASK;
                        wr_q    <= 1'b1;
                        state   <= WRITE;
                    end else if (line.line_read) begin
                        addr_q  <= line.line_address & LINE_MASK;
                        rd_q    <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (mem.mem_resp) begin
                        rdata_q[BEAT_BITS*beat +: BEAT_BITS] <= mem.mem_rdata;
                        beat <= beat + 2'd1;
                        if (beat == LAST_BEAT) begin
                            rd_q   <= 1'b0;
                            resp_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (mem.mem_resp) begin
                        beat <= beat + 2'd1;
                        if (beat == LAST_BEAT) begin
                            wr_q   <= 1'b0;
                            resp_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    beat     <= '0;
                    hold_cnt <= '0;
                    state    <= (HOLDOFF > 0) ? HOLD : IDLE;
                end
                HOLD: begin
                    // Masks the cache's registered request, which drops a cycle or two late.
                    hold_cnt <= hold_cnt + 8'd1;
                    if (hold_cnt == 8'(HOLDOFF - 1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign line.line_rdata = rdata_q;
    assign line.line_resp  = resp_q;
    assign mem.mem_address = addr_q;
    assign mem.mem_read    = rd_q;
    assign mem.mem_write   = wr_q;
    assign mem.mem_wdata   = wdata_q[BEAT_BITS*beat +: BEAT_BITS];

endmodule

// File: tb/tb_pmem_line_adapter.sv
// Directed bench for pmem_line_adapter: read/write bursts, priority, holdoff,
// mid-burst reset and stray memory responses, with hand-derived expectations.
module tb_pmem_line_adapter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pmem_line_if  lif();
    pmem_burst_if bif();

    pmem_line_adapter #(.HOLDOFF(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .line (lif),
        .mem  (bif)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_in(input logic [63:0] d);
        bif.mem_resp  = 1'b1;
        bif.mem_rdata = d;
        step();
        bif.mem_resp  = 1'b0;
    endtask

    // Zero-wait read; returns in the first IDLE cycle after holdoff.
    task automatic run_read(input logic [31:0] addr, input logic [255:0] ln);
        lif.line_address = addr;
        lif.line_read    = 1'b1;
        step();
        chk("rr_mem_read", bif.mem_read, 1'b1);
        chk("rr_addr", bif.mem_address, {addr[31:5], 5'b0});
        for (int k = 0; k < 4; k++) beat_in(ln[64*k +: 64]);
        chk("rr_resp_c5", lif.line_resp, 1'b1);
        chk("rr_rdata", lif.line_rdata, ln);
        lif.line_read = 1'b0;
        step();
        chk("rr_resp_one_cycle", lif.line_resp, 1'b0);
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rd_line, rd2_line, wr_line, bh_line, rd3_line;
        logic [63:0]  wbeat;
        int n_resp;

        rst = 1'b1;
        lif.line_address = '0; lif.line_read = 1'b0; lif.line_write = 1'b0; lif.line_wdata = '0;
        bif.mem_rdata = '0; bif.mem_resp = 1'b0;
        step(); step();
        chk("rst_line_resp", lif.line_resp, 1'b0);
        chk("rst_mem_read", bif.mem_read, 1'b0);
        chk("rst_mem_write", bif.mem_write, 1'b0);
        chk("rst_mem_addr", bif.mem_address, 32'h0);
        chk("rst_rdata", lif.line_rdata, 256'h0);
        rst = 1'b0;

        // Zero-wait read at 0x1234: resp at cycle 5.
        rd_line = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        lif.line_address = 32'h0000_1234;
        lif.line_read    = 1'b1;
        step();
        chk("rd_mem_read_c1", bif.mem_read, 1'b1);
        chk("rd_mem_addr", bif.mem_address, 32'h0000_1220);
        for (int k = 0; k < 4; k++) begin
            chk("rd_no_early_resp", lif.line_resp, 1'b0);
            beat_in(rd_line[64*k +: 64]);
        end
        chk("rd_resp_c5", lif.line_resp, 1'b1);
        chk("rd_rdata", lif.line_rdata, rd_line);
        chk("rd_mem_read_c5", bif.mem_read, 1'b0);

        // line_read left high: cycles 6,7 in HOLD, sampled at 8, burst at 9.
        step();
        chk("hold_c6_read", bif.mem_read, 1'b0);
        chk("hold_c6_resp", lif.line_resp, 1'b0);
        step();
        chk("hold_c7_read", bif.mem_read, 1'b0);
        step();
        chk("hold_c8_read", bif.mem_read, 1'b0);
        step();
        chk("hold_c9_new_burst", bif.mem_read, 1'b1);

        // Reset after two beats of that burst.
        beat_in({8{8'hAA}});
        beat_in({8{8'hBB}});
        lif.line_read = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_mem_read", bif.mem_read, 1'b0);
        chk("abort_resp", lif.line_resp, 1'b0);
        n_resp = 0;
        for (int i = 0; i < 4; i++) begin
            if (lif.line_resp) n_resp++;
            step();
        end
        chk("abort_no_resp", n_resp, 0);

        rd2_line = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                    64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_1234_5678};
        run_read(32'h0000_2010, rd2_line);

        // Stray mem_resp in IDLE must not touch anything.
        for (int i = 0; i < 3; i++) begin
            bif.mem_resp  = 1'b1;
            bif.mem_rdata = {$urandom, $urandom};
            step();
            chk("idle_resp_rdata", lif.line_rdata, rd2_line);
            chk("idle_resp_busy", {bif.mem_read, bif.mem_write, lif.line_resp}, 3'b000);
        end
        bif.mem_resp = 1'b0;

        // Write of word k = k at 0x40 with two-cycle gaps between beats.
        for (int k = 0; k < 8; k++) wr_line[32*k +: 32] = k;
        lif.line_address = 32'h0000_0040;
        lif.line_wdata   = wr_line;
        lif.line_write   = 1'b1;
        step();
        lif.line_wdata = '1;
        chk("wr_mem_write", bif.mem_write, 1'b1);
        chk("wr_mem_read", bif.mem_read, 1'b0);
        chk("wr_addr", bif.mem_address, 32'h0000_0040);
        for (int k = 0; k < 4; k++) begin
            step(); step();
            wbeat = {32'(2*k + 1), 32'(2*k)};
            chk("wr_wdata", bif.mem_wdata, wbeat);
            chk("wr_gap_hold", bif.mem_write, 1'b1);
            beat_in(64'h0);
        end
        n_resp = 0;
        for (int i = 0; i < 6; i++) begin
            if (lif.line_resp) begin
                n_resp++;
                lif.line_write = 1'b0;
            end
            step();
        end
        lif.line_write = 1'b0;
        chk("wr_resp_count", n_resp, 1);
        chk("wr_rdata_untouched", lif.line_rdata, rd2_line);

        // Both requests high: write first, then the read after holdoff.
        bh_line  = {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
                    64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
        rd3_line = {64'h9999_8888_7777_6666, 64'h5555_4444_3333_2222,
                    64'h1111_0000_FFFF_EEEE, 64'hDDDD_CCCC_BBBB_AAAA};
        lif.line_address = 32'h0000_0080;
        lif.line_wdata   = bh_line;
        lif.line_write   = 1'b1;
        lif.line_read    = 1'b1;
        step();
        chk("both_write_first", {bif.mem_write, bif.mem_read}, 2'b10);
        for (int k = 0; k < 4; k++) beat_in(64'h0);
        chk("both_wr_resp", lif.line_resp, 1'b1);
        lif.line_write = 1'b0;
        step(); step(); step(); step();
        chk("both_then_read", {bif.mem_write, bif.mem_read}, 2'b01);
        chk("both_read_addr", bif.mem_address, 32'h0000_0080);
        for (int k = 0; k < 4; k++) beat_in(rd3_line[64*k +: 64]);
        chk("both_rd_resp", lif.line_resp, 1'b1);
        chk("both_rd_rdata", lif.line_rdata, rd3_line);
        lif.line_read = 1'b0;
        step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
